mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit between the EX/MEM pipeline registers and a 64-bit data memory with a ready handshake.
- Latches one access per request, builds byte strobes and a shifted write word, and stalls the pipeline until the memory responds.
- For loads, returns the sign- or zero-extended value to MEM/WB.
- Replaces the raw tri-state data bus with an explicit request/ready interface.

---
 rtl/mem_stage_lsu.sv | 156 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: latches one EX/MEM access, drives a 64-bit ready-handshaked memory, extends load data.
// Latency >= 2 stall cycles per access; optional LSU_MISALIGN_TRAP_EN traps misaligned accesses without a memory request.
module mem_stage_lsu #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              stall,
  output logic              ld_valid,
  output logic [63:0]       ld_data,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wstrb,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [63:0]       mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]        state;
  logic              we_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wait_cnt;
  logic              err_q;

  logic [2:0]  off;
  logic [7:0]  strb_base;
  logic [63:0] wdata_base;
  logic [63:0] shifted;
  logic [63:0] ld_ext;
  logic        in_access;

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return |a[1:0];
      default: return |a;
    endcase
  endfunction
`endif

  // Offset masked to natural alignment; func3[1:0]=11 covers both LD/SD and the 111 alias.
  always_comb begin
    off        = 3'd0;
    strb_base  = 8'hFF;
    wdata_base = wdata_q;
    case (func3_q[1:0])
      2'b00: begin
        off        = addr_q[2:0];
        strb_base  = 8'h01;
        wdata_base = {56'd0, wdata_q[7:0]};
      end
      2'b01: begin
        off        = {addr_q[2:1], 1'b0};
        strb_base  = 8'h03;
        wdata_base = {48'd0, wdata_q[15:0]};
      end
      2'b10: begin
        off        = {addr_q[2], 2'b00};
        strb_base  = 8'h0F;
        wdata_base = {32'd0, wdata_q[31:0]};
      end
      default: begin
        off        = 3'd0;
        strb_base  = 8'hFF;
        wdata_base = wdata_q;
      end
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off, 3'b000};
    ld_ext  = shifted;
    case (func3_q[1:0])
      2'b00:   ld_ext = func3_q[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'b01:   ld_ext = func3_q[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   ld_ext = func3_q[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: ld_ext = shifted;
    endcase
  end

  assign in_access = (state == ACCESS);
  assign mem_req   = in_access;
  assign mem_we    = in_access && we_q;
  assign mem_addr  = in_access ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign mem_wstrb = (in_access && we_q) ? (strb_base << off) : 8'h00;
  assign mem_wdata = (in_access && we_q) ? (wdata_base << {off, 3'b000}) : 64'd0;
  assign stall     = !rst && (((state == IDLE) && req_valid) || in_access);
  assign ld_valid  = (state == DONE) && !we_q && !err_q;
  assign err       = (state == DONE) && err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      func3_q  <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 64'd0;
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
      ld_data  <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            func3_q  <= req_func3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
            state    <= ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misaligned(req_func3, req_addr[2:0])) begin
              err_q   <= 1'b1;
              ld_data <= 64'd0;
              state   <= DONE;
            end
`endif
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (!we_q) ld_data <= ld_ext;
            state <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            err_q    <= 1'b1;
            ld_data  <= 64'd0;
            wait_cnt <= 8'd0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed accesses push expected memory and completion records, a monitor checks them.
module tb_mem_stage_lsu;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        err;
    logic        ldv;
    logic        cmp_data;
    logic [63:0] data;
    int          stalls;
    int          reqs;
  } done_exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        stall;
  logic        ld_valid;
  logic [63:0] ld_data;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;

  int vectors = 0;
  int fails   = 0;
  int ready_delay = -1;

  mem_exp_t  mq[$];
  done_exp_t dq[$];

  mem_stage_lsu #(.ADDR_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_mem(input logic [31:0] a, input logic we, input logic [7:0] s, input logic [63:0] d);
    mem_exp_t e;
    e.addr = a; e.we = we; e.strb = s; e.wdata = d;
    mq.push_back(e);
  endtask

  task automatic expect_done(input logic e_err, input logic e_ldv, input logic e_cmp,
                             input logic [63:0] e_data, input int e_st, input int e_rq);
    done_exp_t e;
    e.err = e_err; e.ldv = e_ldv; e.cmp_data = e_cmp; e.data = e_data;
    e.stalls = e_st; e.reqs = e_rq;
    dq.push_back(e);
  endtask

  // Memory model: accept after ready_delay waiting cycles, never if negative.
  initial begin
    int rcnt;
    rcnt = 0;
    mem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !rst) begin
        mem_ready = (ready_delay >= 0) && (rcnt == ready_delay);
        rcnt++;
      end else begin
        mem_ready = 1'b0;
        rcnt = 0;
      end
    end
  end

  // Monitor: a completion is the cycle where stall falls after being high.
  initial begin
    int stall_cnt, req_cnt;
    logic prev_stall, done_now;
    mem_exp_t  me;
    done_exp_t de;
    stall_cnt = 0; req_cnt = 0; prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0; req_cnt = 0; prev_stall = 1'b0;
      end else begin
        if (mem_req && mem_ready) begin
          if (mq.size() == 0) chk("unexpected_mem_access", 64'd1, 64'd0);
          else begin
            me = mq.pop_front();
            chk("mem_addr",  64'(mem_addr),  64'(me.addr));
            chk("mem_we",    64'(mem_we),    64'(me.we));
            chk("mem_wstrb", 64'(mem_wstrb), 64'(me.strb));
            chk("mem_wdata", mem_wdata,      me.wdata);
          end
        end
        done_now = prev_stall && !stall;
        if (done_now) begin
          if (dq.size() == 0) chk("unexpected_completion", 64'd1, 64'd0);
          else begin
            de = dq.pop_front();
            chk("err",          64'(err),       64'(de.err));
            chk("ld_valid",     64'(ld_valid),  64'(de.ldv));
            if (de.cmp_data) chk("ld_data", ld_data, de.data);
            chk("stall_cycles", 64'(stall_cnt), 64'(de.stalls));
            chk("mem_req_cycles", 64'(req_cnt), 64'(de.reqs));
          end
          stall_cnt = 0; req_cnt = 0;
        end else begin
          if (ld_valid || err) chk("stray_pulse", {62'd0, ld_valid, err}, 64'd0);
          stall_cnt += int'(stall);
          req_cnt   += int'(mem_req);
        end
        prev_stall = stall;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] rd, input int dly,
                       input logic scramble);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
    mem_rdata = rd; ready_delay = dly;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (scramble) begin
        req_valid = 1'b0; req_we = ~we; req_func3 = 3'b011;
        req_addr = 32'hFFFF_FFF8; req_wdata = '1;
      end
    end while (stall && n < 200);
    if (n >= 200) chk("access_timeout_bound", 64'd1, 64'd0);
    req_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},     64'(stall),     64'd0);
    chk({tag, "_ld_valid"},  64'(ld_valid),  64'd0);
    chk({tag, "_ld_data"},   ld_data,        64'd0);
    chk({tag, "_err"},       64'(err),       64'd0);
    chk({tag, "_mem_req"},   64'(mem_req),   64'd0);
    chk({tag, "_mem_we"},    64'(mem_we),    64'd0);
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
    req_addr = 32'd0; req_wdata = 64'd0; mem_rdata = 64'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_all_zero("reset");

    // LW 0x104: upper word 0x8000_0001 sign-extended
    expect_mem(32'h100, 1'b0, 8'h00, 64'd0);
    expect_done(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0001, 2, 1);
    issue(1'b0, 3'b010, 32'h104, 64'd0, 64'h8000_0001_1234_5678, 0, 1'b0);

    // SB 0x3
    expect_mem(32'h0, 1'b1, 8'h08, 64'h0000_0000_AB00_0000);
    expect_done(1'b0, 1'b0, 1'b0, 64'd0, 2, 1);
    issue(1'b1, 3'b000, 32'h3, 64'hAB, 64'd0, 0, 1'b0);

    // LHU 0x6 with 3 wait cycles; request inputs scrambled after latching
    expect_mem(32'h0, 1'b0, 8'h00, 64'd0);
    expect_done(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_F00D, 5, 4);
    issue(1'b0, 3'b101, 32'h6, 64'd0, 64'hF00D_0000_0000_0000, 3, 1'b1);

    // Timeout: LD with memory never ready, MAX_WAIT=4
    expect_done(1'b1, 1'b0, 1'b1, 64'd0, 5, 4);
    issue(1'b0, 3'b011, 32'h8, 64'd0, 64'h5555_5555_5555_5555, -1, 1'b0);

    // SW 0x14
    expect_mem(32'h10, 1'b1, 8'hF0, 64'hDEAD_BEEF_0000_0000);
    expect_done(1'b0, 1'b0, 1'b0, 64'd0, 2, 1);
    issue(1'b1, 3'b010, 32'h14, 64'hDEAD_BEEF, 64'd0, 0, 1'b0);

    // SH 0x22 with a 1-cycle wait
    expect_mem(32'h20, 1'b1, 8'h0C, 64'h0000_0000_1234_0000);
    expect_done(1'b0, 1'b0, 1'b0, 64'd0, 3, 2);
    issue(1'b1, 3'b001, 32'h22, 64'h1234, 64'd0, 1, 1'b0);

    // SW with func3[2] set behaves as SW
    expect_mem(32'h0, 1'b1, 8'hF0, 64'h5566_7788_0000_0000);
    expect_done(1'b0, 1'b0, 1'b0, 64'd0, 2, 1);
    issue(1'b1, 3'b110, 32'h4, 64'h5566_7788, 64'd0, 0, 1'b0);

    // LB 0x5 negative byte
    expect_mem(32'h0, 1'b0, 8'h00, 64'd0);
    expect_done(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 2, 1);
    issue(1'b0, 3'b000, 32'h5, 64'd0, 64'h0000_8000_0000_0000, 0, 1'b0);

    // LBU 0x7
    expect_mem(32'h0, 1'b0, 8'h00, 64'd0);
    expect_done(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_009A, 2, 1);
    issue(1'b0, 3'b100, 32'h7, 64'd0, 64'h9A00_0000_0000_0000, 0, 1'b0);

    // LH 0x2 negative half
    expect_mem(32'h0, 1'b0, 8'h00, 64'd0);
    expect_done(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 2, 1);
    issue(1'b0, 3'b001, 32'h2, 64'd0, 64'h0000_0000_8001_0000, 0, 1'b0);

    // LWU 0x0
    expect_mem(32'h0, 1'b0, 8'h00, 64'd0);
    expect_done(1'b0, 1'b1, 1'b1, 64'h0000_0000_9ABC_DEF0, 2, 1);
    issue(1'b0, 3'b110, 32'h0, 64'd0, 64'h1234_5678_9ABC_DEF0, 0, 1'b0);

    // func3=111 treated as LD
    expect_mem(32'h18, 1'b0, 8'h00, 64'd0);
    expect_done(1'b0, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 2, 1);
    issue(1'b0, 3'b111, 32'h18, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned LW and SH trap without touching memory
    expect_done(1'b1, 1'b0, 1'b0, 64'd0, 1, 0);
    issue(1'b0, 3'b010, 32'h2, 64'd0, 64'h1111_2222_8765_4321, 0, 1'b0);
    expect_done(1'b1, 1'b0, 1'b0, 64'd0, 1, 0);
    issue(1'b1, 3'b001, 32'h5, 64'hBEEF, 64'd0, 0, 1'b0);
`else
    // Misaligned accesses are masked to natural alignment
    expect_mem(32'h0, 1'b0, 8'h00, 64'd0);
    expect_done(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_8765_4321, 2, 1);
    issue(1'b0, 3'b010, 32'h2, 64'd0, 64'h1111_2222_8765_4321, 0, 1'b0);
    expect_mem(32'h0, 1'b1, 8'h30, 64'h0000_BEEF_0000_0000);
    expect_done(1'b0, 1'b0, 1'b0, 64'd0, 2, 1);
    issue(1'b1, 3'b001, 32'h5, 64'hBEEF, 64'd0, 0, 1'b0);
`endif

    // Reset mid-access abandons it
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b011; req_addr = 32'h40; ready_delay = -1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_access_mem_req", 64'(mem_req), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("mid_reset");

    // SD after reset completes normally
    expect_mem(32'h30, 1'b1, 8'hFF, 64'hCAFE_F00D_1234_5678);
    expect_done(1'b0, 1'b0, 1'b0, 64'd0, 2, 1);
    issue(1'b1, 3'b011, 32'h30, 64'hCAFE_F00D_1234_5678, 64'd0, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("mem_queue_drained",  64'(mq.size()), 64'd0);
    chk("done_queue_drained", 64'(dq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
